// File: rtl/reg_write_arbiter_if.sv
// Write-request bus between the requesting units and reg_write_arbiter.
//   master : requester side, drives req/req_addr/req_data, sees gnt and bank signals
//   slave  : arbiter side, samples requests, drives gnt/load/wr_data/busy
// Signals:
//   req       per-requester write request, held until gnt
//   req_addr  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt       one-hot grant pulse, one cycle, marks the write as performed
//   load      one-hot load enable to the register bank
//   wr_data   data presented to the register bank
//   busy      at least one eligible request was seen at the last edge
interface reg_write_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REGS-1:0]       load;
  logic [DATA_W-1:0]         wr_data;
  logic                      busy;

  modport master (
    output req, req_addr, req_data,
    input  gnt, load, wr_data, busy
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, load, wr_data, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the shared write port of a load-enable register bank.
// At most one pending write is granted per cycle; the winner's address is decoded
// into a one-hot load vector and its data is presented on wr_data. All outputs
// are registered.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high; clears outputs and the round-robin pointer
//   bus    reg_write_arbiter_if.slave (req/req_addr/req_data in, gnt/load/wr_data/busy out)
// Configuration macro:
//   REG0_LOCK_EN  when defined, address 0 is a constant-zero register: requests to it
//                 are still granted but load[0] never asserts.
module reg_write_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned DATA_W   = 16
) (
  input logic                clock,
  input logic                reset,
  reg_write_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REGS-1:0] load_q, load_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]  eligible;
  logic                found;
  logic [PTR_W-1:0]    winner;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                writable;

  always_comb begin
    // A requester granted this cycle is masked so it cannot be granted again
    // while it is still dropping req.
    eligible = bus.req & ~gnt_q;

    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end

    win_addr = bus.req_addr[32'(winner) * ADDR_W +: ADDR_W];
    win_data = bus.req_data[32'(winner) * DATA_W +: DATA_W];

    // Out-of-range addresses still get a grant but never touch the bank.
    writable = (32'(win_addr) < NUM_REGS);
`ifdef REG0_LOCK_EN
    if (win_addr == '0) begin
      writable = 1'b0;
    end
`else
`endif

    gnt_d     = '0;
    load_d    = '0;
    wr_data_d = wr_data_q;
    rr_ptr_d  = rr_ptr_q;
    busy_d    = |eligible;

    if (found) begin
      gnt_d[winner] = 1'b1;
      wr_data_d     = win_data;
      rr_ptr_d      = PTR_W'((32'(winner) + 1) % NUM_REQ);
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        load_d[r] = writable && (32'(win_addr) == r);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gnt_q     <= '0;
      load_q    <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      gnt_q     <= gnt_d;
      load_q    <= load_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.load    = load_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter. A queue-based reference model
// predicts grants, bank load, write data and busy; an environment register bank
// captures wr_data on load and is compared against the model's bank.
module tb_reg_write_arbiter;

  localparam int NREQ  = 4;
  localparam int NREGS = 8;
  localparam int AW    = 3;
  localparam int DW    = 16;

`ifdef REG0_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clock;
  logic reset;

  reg_write_arbiter_if #(.NUM_REQ(4), .NUM_REGS(8), .ADDR_W(3), .DATA_W(16)) u_if ();
  reg_write_arbiter_if #(.NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3), .DATA_W(16)) u_if6 ();

  reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .ADDR_W(3), .DATA_W(16)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(6), .ADDR_W(3), .DATA_W(16)) u_dut6 (
    .clock (clock),
    .reset (reset),
    .bus   (u_if6.slave)
  );

  always #5 clock = ~clock;

  // Environment register bank fed by the arbiter.
  logic [DW-1:0] bank [NREGS];
  always @(posedge clock) begin
    for (int r = 0; r < NREGS; r++) begin
      if (u_if.load[r]) bank[r] <= u_if.wr_data;
    end
  end

  int n_checks;
  int n_fail;

  // Reference model state: what the DUT outputs should be in the current cycle.
  logic [NREQ-1:0]  m_gnt;
  logic [NREGS-1:0] m_load;
  logic [DW-1:0]    m_wr;
  logic             m_busy;
  int               m_ptr;
  logic [DW-1:0]    m_bank [NREGS];

  task automatic model_reset();
    m_gnt  = '0;
    m_load = '0;
    m_wr   = '0;
    m_busy = 1'b0;
    m_ptr  = 0;
  endtask

  // One rising edge as seen by the model: the bank captures what is presented
  // now, then the next grant is chosen from the requests visible at the edge.
  task automatic model_edge();
    logic [NREQ-1:0] elig;
    int order[$];
    int w;
    int a;
    for (int r = 0; r < NREGS; r++) begin
      if (m_load[r]) m_bank[r] = m_wr;
    end
    elig = u_if.req & ~m_gnt;
    order = {};
    for (int k = 0; k < NREQ; k++) begin
      if (elig[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
    end
    m_busy = |elig;
    m_gnt  = '0;
    m_load = '0;
    if (order.size() > 0) begin
      w = order[0];
      a = int'(u_if.req_addr[w*AW +: AW]);
      m_gnt[w] = 1'b1;
      m_wr     = u_if.req_data[w*DW +: DW];
      if (!(LOCK && a == 0)) m_load[a] = 1'b1;
      m_ptr = (w + 1) % NREQ;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (u_if.gnt !== '0 || u_if.load !== '0 || u_if.wr_data !== '0 || u_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: gnt=%b load=%b wr_data=%h busy=%b, required all zero",
               u_if.gnt, u_if.load, u_if.wr_data, u_if.busy);
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();

    u_if.req = 4'b0010;
    u_if.req_addr[1*AW +: AW] = 3'd4;
    u_if.req_data[1*DW +: DW] = 16'h1234;
    tick();
    n_checks++;
    if (u_if.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_pregrant: gnt=%b required 0010", u_if.gnt);
    end

    // Reset lands in the middle of the grant cycle.
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (u_if.gnt !== '0 || u_if.load !== '0 || u_if.wr_data !== '0 || u_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: gnt=%b load=%b wr_data=%h busy=%b, required all zero",
               u_if.gnt, u_if.load, u_if.wr_data, u_if.busy);
    end
    u_if.req = '0;
    @(posedge clock);
    #1;
    n_checks++;
    if (bank[4] !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_dropped_write: reg4=%h required 0000", bank[4]);
    end
    reset = 1'b0;

    u_if.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      u_if.req_addr[i*AW +: AW] = AW'(i + 1);
      u_if.req_data[i*DW +: DW] = DW'(16'hA000 + i);
    end
    tick();
    n_checks++;
    if (u_if.gnt !== 4'b0001 || u_if.gnt !== m_gnt) begin
      n_fail++;
      $display("FAIL reset_first_grant: gnt=%b required 0001", u_if.gnt);
    end
    u_if.req = '0;
    tick();
    tick();
    n_checks++;
    if (bank[1] !== 16'hA000) begin
      n_fail++;
      $display("FAIL reset_first_write: reg1=%h required a000", bank[1]);
    end
  endtask

  task automatic test_single();
    u_if.req = 4'b0100;
    u_if.req_addr[2*AW +: AW] = 3'd5;
    u_if.req_data[2*DW +: DW] = 16'hBEEF;
    tick();
    n_checks++;
    if (u_if.gnt !== 4'b0100 || u_if.load !== 8'b0010_0000 || u_if.wr_data !== 16'hBEEF ||
        u_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%b load=%b wr_data=%h busy=%b, required 0100 00100000 beef 1",
               u_if.gnt, u_if.load, u_if.wr_data, u_if.busy);
    end
    u_if.req = '0;
    tick();
    n_checks++;
    if (u_if.gnt !== '0 || u_if.load !== '0 || u_if.wr_data !== 16'hBEEF || u_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: gnt=%b load=%b wr_data=%h busy=%b, required 0 0 beef 0",
               u_if.gnt, u_if.load, u_if.wr_data, u_if.busy);
    end
    n_checks++;
    if (bank[5] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL single_bank: reg5=%h required beef", bank[5]);
    end
  endtask

  // Pointer is at 3 here (last grant went to requester 2).
  task automatic test_collision();
    u_if.req = 4'b1001;
    u_if.req_addr[0*AW +: AW] = 3'd2;
    u_if.req_addr[3*AW +: AW] = 3'd2;
    u_if.req_data[0*DW +: DW] = 16'h1111;
    u_if.req_data[3*DW +: DW] = 16'h3333;
    tick();
    n_checks++;
    if (u_if.gnt !== 4'b1000 || u_if.load !== 8'b0000_0100 || u_if.wr_data !== 16'h3333) begin
      n_fail++;
      $display("FAIL collision_first: gnt=%b load=%b wr_data=%h, required 1000 00000100 3333",
               u_if.gnt, u_if.load, u_if.wr_data);
    end
    u_if.req = 4'b0001;
    tick();
    n_checks++;
    if (u_if.gnt !== 4'b0001 || u_if.load !== 8'b0000_0100 || u_if.wr_data !== 16'h1111) begin
      n_fail++;
      $display("FAIL collision_second: gnt=%b load=%b wr_data=%h, required 0001 00000100 1111",
               u_if.gnt, u_if.load, u_if.wr_data);
    end
    u_if.req = '0;
    tick();
    n_checks++;
    if (bank[2] !== 16'h1111) begin
      n_fail++;
      $display("FAIL collision_bank: reg2=%h required 1111", bank[2]);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] prev;
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    u_if.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      u_if.req_addr[i*AW +: AW] = AW'($urandom_range(7, 1));
      u_if.req_data[i*DW +: DW] = DW'($urandom);
    end
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (u_if.gnt !== NREQ'(1 << (k % NREQ)) || u_if.gnt === prev ||
          u_if.wr_data !== m_wr || u_if.load !== m_load) begin
        n_fail++;
        $display("FAIL fairness_cycle%0d: gnt=%b wr_data=%h load=%b, required gnt=%b wr_data=%h load=%b",
                 k, u_if.gnt, u_if.wr_data, u_if.load, NREQ'(1 << (k % NREQ)), m_wr, m_load);
      end
      prev = u_if.gnt;
    end
    u_if.req = '0;
    tick();
    tick();
  endtask

  task automatic test_range();
    u_if6.req = 4'b0010;
    u_if6.req_addr[1*AW +: AW] = 3'd7;
    u_if6.req_data[1*DW +: DW] = 16'h5A5A;
    tick();
    n_checks++;
    if (u_if6.gnt !== 4'b0010 || u_if6.load !== 6'b000000) begin
      n_fail++;
      $display("FAIL range_oob: gnt=%b load=%b, required 0010 000000", u_if6.gnt, u_if6.load);
    end
    u_if6.req = 4'b0001;
    u_if6.req_addr[0*AW +: AW] = 3'd5;
    u_if6.req_data[0*DW +: DW] = 16'h0F0F;
    tick();
    n_checks++;
    if (u_if6.gnt !== 4'b0001 || u_if6.load !== 6'b100000 || u_if6.wr_data !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL range_top: gnt=%b load=%b wr_data=%h, required 0001 100000 0f0f",
               u_if6.gnt, u_if6.load, u_if6.wr_data);
    end
    u_if6.req = '0;
    tick();
  endtask

  task automatic test_lock();
    u_if.req = 4'b0010;
    u_if.req_addr[1*AW +: AW] = 3'd0;
    u_if.req_data[1*DW +: DW] = 16'hFFFF;
    tick();
    n_checks++;
    if (u_if.gnt !== 4'b0010 || u_if.load !== (LOCK ? 8'h00 : 8'h01)) begin
      n_fail++;
      $display("FAIL lock_grant: gnt=%b load=%b, required 0010 %b",
               u_if.gnt, u_if.load, (LOCK ? 8'h00 : 8'h01));
    end
    u_if.req = '0;
    tick();
    n_checks++;
    if (bank[0] !== (LOCK ? 16'h0000 : 16'hFFFF)) begin
      n_fail++;
      $display("FAIL lock_bank: reg0=%h required %h", bank[0], (LOCK ? 16'h0000 : 16'hFFFF));
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i]) begin
          // Request served; sometimes issue a fresh one straight away.
          if ($urandom_range(3) == 0) begin
            u_if.req[i] = 1'b1;
            u_if.req_addr[i*AW +: AW] = AW'($urandom_range(7));
            u_if.req_data[i*DW +: DW] = DW'($urandom);
          end else begin
            u_if.req[i] = 1'b0;
          end
        end else if (u_if.req[i]) begin
          if ($urandom_range(15) == 0) u_if.req[i] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          u_if.req[i] = 1'b1;
          u_if.req_addr[i*AW +: AW] = AW'($urandom_range(7));
          u_if.req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      tick();
      n_checks++;
      if (u_if.gnt !== m_gnt || u_if.load !== m_load || u_if.wr_data !== m_wr ||
          u_if.busy !== m_busy) begin
        n_fail++;
        $display("FAIL random_cycle%0d: gnt=%b load=%b wr_data=%h busy=%b, required %b %b %h %b",
                 c, u_if.gnt, u_if.load, u_if.wr_data, u_if.busy, m_gnt, m_load, m_wr, m_busy);
      end
    end
    u_if.req = '0;
    tick();
    tick();
    for (int r = 0; r < NREGS; r++) begin
      n_checks++;
      if (bank[r] !== m_bank[r]) begin
        n_fail++;
        $display("FAIL random_bank_reg%0d: value=%h required %h", r, bank[r], m_bank[r]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clock    = 1'b0;
    reset    = 1'b1;
    u_if.req       = '0;
    u_if.req_addr  = '0;
    u_if.req_data  = '0;
    u_if6.req      = '0;
    u_if6.req_addr = '0;
    u_if6.req_data = '0;
    for (int r = 0; r < NREGS; r++) begin
      bank[r]   = '0;
      m_bank[r] = '0;
    end
    model_reset();

    test_reset();
    test_single();
    test_collision();
    test_fairness();
    test_range();
    test_lock();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
